// File: rtl/dbus_sram_responder.sv
module dbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        db_req_v,
  output logic        db_req_r,
  input  logic        db_req_we,
  input  logic [31:0] db_req_addr,
  input  logic [31:0] db_req_wdata,
  input  logic [3:0]  db_req_be,
  output logic        db_resp_v,
  output logic [31:0] db_resp_rdata,
  output logic        db_resp_err
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LP_BASE     = {1'b0, BASE_ADDR};
  // 33-bit limit so a window ending at 2^32 does not wrap to zero
  localparam logic [32:0] LP_LIMIT    = LP_BASE + (33'(DEPTH_WORDS) << 2);
  localparam logic [4:0]  LP_CNT_LOAD = (LATENCY > 1) ? 5'(LATENCY - 2) : 5'd0;

  if (LATENCY < 1 || LATENCY > 32) begin : g_bad_latency
    $fatal(1, "dbus_sram_responder: LATENCY must be in 1..32");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_req_r;
  logic [4:0]    r_cnt;
  logic [31:0]   r_pend_rdata;
  logic          r_pend_err;
  logic          r_resp_v;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_err;
  logic [32:0]   w_addr33;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_acc_rdata;

  assign w_accept    = db_req_v && r_req_r;
  assign w_addr33    = {1'b0, db_req_addr};
  assign w_err       = (db_req_addr[1:0] != 2'b00) || (w_addr33 < LP_BASE) ||
                       (w_addr33 >= LP_LIMIT);
  assign w_idx       = AW'((db_req_addr - BASE_ADDR) >> 2);
  assign w_acc_rdata = (db_req_we || w_err) ? '0 : r_mem[w_idx];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_r      <= 1'b0;
      r_cnt        <= '0;
      r_pend_rdata <= '0;
      r_pend_err   <= 1'b0;
      r_resp_v     <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_req_r  <= (w_next == IDLE);
      r_resp_v <= (w_next == RESP);

      if (w_accept)
        r_cnt <= LP_CNT_LOAD;
      else if (r_state == BUSY && r_cnt != '0)
        r_cnt <= r_cnt - 5'd1;

      if (w_accept) begin
        r_pend_rdata <= w_acc_rdata;
        r_pend_err   <= w_err;
      end

      // Entering RESP straight from IDLE (LATENCY==1) bypasses the
      // pending registers, which are loaded on that same edge.
      if (w_next == RESP) begin
        r_resp_rdata <= (r_state == IDLE) ? w_acc_rdata : r_pend_rdata;
        r_resp_err   <= (r_state == IDLE) ? w_err       : r_pend_err;
      end else begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && db_req_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (db_req_be[i])
          r_mem[w_idx][8*i +: 8] <= db_req_wdata[8*i +: 8];
      end
    end
  end

  assign db_req_r      = r_req_r;
  assign db_resp_v     = r_resp_v;
  assign db_resp_rdata = r_resp_rdata;
  assign db_resp_err   = r_resp_err;

endmodule
